// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM states, default word width, mode-0
// idle level and input pipe depth.
// Macro SPI_RX_SYNC_EN: when defined, each SPI input runs through a 2-flop
// synchronizer; when undefined, a single register stage is used and the
// inputs are treated as synchronous to clock.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_WORD_W = 8;

  // Mode 0: sclk idles low, data is sampled on the rising edge.
  localparam int   SPI_MODE      = 0;
  localparam logic SPI_SCLK_IDLE = 1'b0;

`ifdef SPI_RX_SYNC_EN
  localparam int SPI_SYNC_DEPTH = 2;
`else
  localparam int SPI_SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/spi_in_sync.sv
// One-bit input pipe for an SPI pin, followed by a single history flop so the
// caller can detect edges.  Depth is SPI_SYNC_DEPTH from spi_pkg, which
// depends on macro SPI_RX_SYNC_EN (2 when defined, 1 when undefined).  All
// three SPI pins use this same block, so their relative timing is preserved.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   d             raw pin
//   q             piped pin value
//   q_d           q delayed by one more clock
import spi_pkg::*;

module spi_in_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_d
);

  logic [SPI_SYNC_DEPTH-1:0] pipe_q, pipe_d;
  logic                      hist_q, hist_d;

  // NOTE: every combinational output gets a default before any branch or loop
  // touches it, so no path can leave it unassigned and infer a latch.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = d;
    for (int i = 1; i < SPI_SYNC_DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    hist_d = pipe_q[SPI_SYNC_DEPTH-1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_q <= {SPI_SYNC_DEPTH{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      pipe_q <= pipe_d;
      hist_q <= hist_d;
    end
  end

  assign q   = pipe_q[SPI_SYNC_DEPTH-1];
  assign q_d = hist_q;

endmodule

// File: rtl/spi_sipo_rx.sv
// SPI mode-0 receive deserializer.  Oversamples sclk/mosi/cs_n in the clock
// domain, shifts WIDTH bits per word (back-to-back within a frame), and
// presents each completed word on a valid/ready port.  A word completing
// while the previous one is still unconsumed is dropped and sets the sticky
// overrun flag.
// Macro SPI_RX_SYNC_EN selects 2-flop input synchronizers (shift on the 3rd
// clock edge after sclk rises) instead of one register stage (2nd edge).
// Ports:
//   clock, reset        system clock (>= 4x sclk), synchronous active-high reset
//   sclk, cs_n, mosi    SPI pins, peripheral side
//   out_data/out_valid  last completed word and its valid flag
//   out_ready           consumer accepts when out_valid && out_ready
//   overrun/overrun_clr sticky dropped-word flag and its clear
//   busy                high while a frame is selected (SHIFT state)
import spi_pkg::*;

module spi_sipo_rx #(
  parameter int WIDTH     = SPI_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_s, sclk_h, mosi_s, mosi_h, cs_s, cs_h;
  logic sclk_rise;
  logic unused_hist;

  spi_in_sync #(.RESET_VAL(SPI_SCLK_IDLE)) u_sync_sclk (
    .clock(clock), .reset(reset), .d(sclk), .q(sclk_s), .q_d(sclk_h)
  );
  spi_in_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .d(mosi), .q(mosi_s), .q_d(mosi_h)
  );
  spi_in_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset(reset), .d(cs_n), .q(cs_s), .q_d(cs_h)
  );

  // Only sclk needs its history; the other two are kept for equal depth.
  assign unused_hist = mosi_h ^ cs_h;
  assign sclk_rise   = sclk_s & ~sclk_h;

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  // Framing and shifting.  done_d marks the final shift of a word; the word
  // is handed to the output stage one clock later from shift_q.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          // Frame ended early or normally: drop any partial word.
          state_d   = IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (sclk_rise) begin
          if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], mosi_s};
          else           shift_d = {mosi_s, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register, handshake and sticky overrun.  A drop sets
  // overrun even if overrun_clr is asserted in the same cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q & ~overrun_clr;
    if (done_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_sipo_rx.sv
// Directed bench for spi_sipo_rx.  An MSB-first instance is the main target;
// an LSB-first instance shares the SPI pins with its consumer always ready.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_spi_sipo_rx;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       out_ready = 1'b0, overrun_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, overrun, busy;
  logic       l_ready = 1'b1;
  logic [7:0] l_data;
  logic       l_valid, l_overrun, l_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  spi_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  spi_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .out_data(l_data), .out_valid(l_valid), .out_ready(l_ready),
    .overrun(l_overrun), .overrun_clr(overrun_clr), .busy(l_busy)
  );

  // One sclk period = 4 clocks: 2 low (mosi set up), 2 high.
  task automatic send_bit(input logic b);
    @(negedge clock) mosi = b;
    @(negedge clock) sclk = 1'b1;
    @(negedge clock);
    @(negedge clock) sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[7-i]);
  endtask

  task automatic start_frame();
    @(negedge clock) cs_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clock);
    cs_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic consume();
    @(negedge clock) out_ready = 1'b1;
    @(negedge clock) out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic use_lsb);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (use_lsb ? l_valid : out_valid) found = 1'b1;
      else @(negedge clock);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL %s: valid never rose within 20 clocks", name);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h exp 00", out_data); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    start_frame();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b exp 1", busy); end
    send_bits(8'hA5, 8);
    wait_valid("single_valid", 1'b0);
    vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h exp a5", out_data); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL single_overrun got %b exp 0", overrun); end
    @(negedge clock);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse got %b exp 0", out_valid); end
    out_ready = 1'b0;
    end_frame();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_overrun();
    start_frame();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    repeat (4) @(negedge clock);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b exp 1", out_valid); end
    vectors++; if (out_data !== 8'h3C) begin miscompares++; $display("FAIL ovr_data got %h exp 3c", out_data); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    consume();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drop_valid got %b exp 0", out_valid); end
    vectors++; if (out_data !== 8'h3C) begin miscompares++; $display("FAIL ovr_hold_data got %h exp 3c", out_data); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    @(negedge clock) overrun_clr = 1'b1;
    @(negedge clock) overrun_clr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clr got %b exp 0", overrun); end
    end_frame();
  endtask

  // out_ready is high only for the clock whose edge loads the new word.
  task automatic test_back_to_back();
    start_frame();
    send_bits(8'h11, 8);
    repeat (4) @(negedge clock);
    vectors++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_hold got %h/%b exp 11/1", out_data, out_valid); end
    send_bits(8'h22, 7);
    @(negedge clock) mosi = 1'b0;
    @(negedge clock) sclk = 1'b1;
    @(negedge clock);
    @(negedge clock) sclk = 1'b0;
    if (LAT == 3) @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock) out_ready = 1'b0;
    vectors++; if (out_data !== 8'h22) begin miscompares++; $display("FAIL b2b_data got %h exp 22", out_data); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    end_frame();
  endtask

  task automatic test_abort();
    consume();
    start_frame();
    send_bits(8'hFF, 5);
    @(negedge clock) cs_n = 1'b1;
    repeat (4) @(negedge clock);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b exp 0", out_valid); end
    start_frame();
    send_bits(8'h7E, 8);
    repeat (4) @(negedge clock);
    vectors++; if (out_data !== 8'h7E || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL abort_next got %h/%b exp 7e/1", out_data, out_valid); end
    end_frame();
  endtask

  task automatic test_reset_mid_word();
    start_frame();
    send_bits(8'hFF, 4);
    @(negedge clock) begin reset = 1'b1; cs_n = 1'b1; end
    @(negedge clock) reset = 1'b0;
    vectors++; if (out_data !== 8'h00 || out_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs got %h/%b/%b/%b exp 00/0/0/0", out_data, out_valid, overrun, busy);
    end
    start_frame();
    send_bits(8'h81, 8);
    repeat (4) @(negedge clock);
    vectors++; if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL midrst_next got %h/%b exp 81/1", out_data, out_valid); end
    end_frame();
  endtask

  // Clock edges from the final sclk rise until out_valid is seen = LAT + 1.
  task automatic test_latency();
    int lat = 0;
    consume();
    start_frame();
    send_bits(8'h00, 7);
    @(negedge clock) mosi = 1'b1;
    @(negedge clock) sclk = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clock);
      #1;
      if (out_valid && lat == 0) lat = n;
    end
    @(negedge clock) sclk = 1'b0;
    vectors++; if (lat !== LAT + 1) begin miscompares++; $display("FAIL latency got %0d exp %0d", lat, LAT + 1); end
    vectors++; if (out_data !== 8'h01) begin miscompares++; $display("FAIL latency_data got %h exp 01", out_data); end
    vectors++; if (l_data !== 8'h80) begin miscompares++; $display("FAIL lsb_order got %h exp 80", l_data); end
    end_frame();
  endtask

  task automatic test_lsb_first();
    start_frame();
    send_bits(8'hA5, 8);
    wait_valid("lsb_valid", 1'b1);
    vectors++; if (l_data !== 8'hA5) begin miscompares++; $display("FAIL lsb_data got %h exp a5", l_data); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
    test_latency();
    test_lsb_first();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
